gray_conv_sched: RTL and testbench

Round-robin scheduler that shares one binary-to-Gray conversion datapath between NREQ requesters. Each requester presents a binary word with a valid/ready handshake. The block grants one requester per cycle, converts its word (gray = bin ^ (bin >> 1)) and holds the result in a single registered output slot, tagged with the requester ID, under downstream backpressure. It sits between the requesting producers and the downstream Gray-code consumer.

---
 rtl/gray_conv_pkg.sv | 27 ++
 rtl/gray_conv_sched_rr_arbiter.sv | 34 +++
 rtl/gray_conv_sched.sv | 129 ++++++++++++
 tb/tb_gray_conv_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_conv_pkg.sv
// Shared types, default sizes and Gray conversion helpers for gray_conv_sched.
package gray_conv_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;
  localparam int MAX_WIDTH = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended inputs leave the low WIDTH bits exact.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] gray);
    logic [MAX_WIDTH-1:0] bin;
    bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
    for (int k = MAX_WIDTH - 2; k >= 0; k--) begin
      bin[k] = bin[k+1] ^ gray[k];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_conv_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i, wrapping.
module rr_arbiter
  import gray_conv_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o,
  output logic            any_o
);

  logic [2*NREQ-1:0] req_rot;
  int                sel;

  always_comb begin
    req_rot     = {req_i, req_i} >> ptr_i;
    any_o       = 1'b0;
    grant_idx_o = '0;
    sel         = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_o && req_rot[k]) begin
        any_o = 1'b1;
        sel   = int'(ptr_i) + k;
        if (sel >= NREQ) sel = sel - NREQ;
        grant_idx_o = IDW'(sel);
      end
    end
    grant_o = any_o ? (NREQ'(1) << grant_idx_o) : '0;
  end

endmodule

// File: rtl/gray_conv_sched.sv
// Round-robin shared binary-to-Gray converter with a single registered output slot.
// Optional GRAY_CONV_DECODE_EN adds per-requester Gray-to-binary decode (req_dir/out_dir).
//
// state | meaning
// EMPTY | output slot free
// FULL  | output slot holds a result (out_valid=1)
module gray_conv_sched
  import gray_conv_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_bin,
`ifdef GRAY_CONV_DECODE_EN
  input  logic [NREQ-1:0]       req_dir,
  output logic                  out_dir,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_gray,
  output logic [IDW-1:0]        out_id
);

  if (IDW != $clog2(NREQ)) begin : g_bad_idw
    $error("IDW must equal clog2(NREQ)");
  end
  if (WIDTH > MAX_WIDTH || WIDTH < 2) begin : g_bad_width
    $error("WIDTH out of range");
  end

  slot_state_e       state_q;
  logic [WIDTH-1:0]  gray_q;
  logic [IDW-1:0]    id_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [IDW-1:0]    rr_ptr_d;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic              any_req;
  logic              can_load;
  logic              accept;
  logic [WIDTH-1:0]  bin_g;
  logic [WIDTH-1:0]  conv_d;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (any_req)
  );

  // A full slot draining this cycle can be refilled in the same cycle.
  assign can_load  = (state_q == EMPTY) || out_ready;
  assign accept    = can_load && any_req && !rst;
  assign req_ready = accept ? grant : '0;
  assign rr_ptr_d  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  always_comb begin
    bin_g = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == IDW'(k)) bin_g = req_bin[k*WIDTH +: WIDTH];
    end
  end

`ifdef GRAY_CONV_DECODE_EN
  logic dir_g;
  logic dir_q;

  always_comb begin
    dir_g = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == IDW'(k)) dir_g = req_dir[k];
    end
  end

  assign conv_d = dir_g ? WIDTH'(gray2bin(MAX_WIDTH'(bin_g)))
                        : WIDTH'(bin2gray(MAX_WIDTH'(bin_g)));

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= 1'b0;
    end else if (accept) begin
      dir_q <= dir_g;
    end
  end

  assign out_dir = dir_q;
`else
  assign conv_d = WIDTH'(bin2gray(MAX_WIDTH'(bin_g)));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      gray_q   <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_q <= FULL;
        FULL:    if (out_ready && !accept) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      if (accept) begin
        gray_q   <= conv_d;
        id_q     <= grant_idx;
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_gray  = gray_q;
  assign out_id    = id_q;

  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_hold_stable:   assert property (@(posedge clk) disable iff (rst)
                     (state_q == FULL && !out_ready) |=> ($stable(gray_q) && $stable(id_q)));

endmodule

// File: tb/tb_gray_conv_sched.sv
// Self-checking bench for gray_conv_sched: vector table, directed corner sequences
// and a randomized run against a behavioural model.
module tb_gray_conv_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_gray;
  logic [IDW-1:0]        out_id;
`ifdef GRAY_CONV_DECODE_EN
  logic [NREQ-1:0]       req_dir;
  logic                  out_dir;
`endif

  gray_conv_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_bin   (req_bin),
`ifdef GRAY_CONV_DECODE_EN
    .req_dir   (req_dir),
    .out_dir   (out_dir),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '1;
    out_ready = 1'b1;
    #1;
    chk("ready_in_reset", int'(req_ready), 0);
    tick();
    tick();
    rst       = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_gray", int'(out_gray), 0);
    chk("rst_out_id", int'(out_id), 0);
    chk("rst_req_ready", int'(req_ready), 0);
  endtask

  typedef struct {
    logic [NREQ-1:0]       valid;
    logic                  ordy;
    logic [NREQ-1:0]       exp_ready;
    logic                  exp_valid;
    logic [WIDTH-1:0]      exp_gray;
    logic [IDW-1:0]        exp_id;
  } vec_t;

  vec_t vecs[11];
  logic [3:0] exp_seq[16];

  // behavioural model state
  logic             m_valid;
  logic [WIDTH-1:0] m_gray;
  int               m_id;
  int               m_ptr;
  logic             pend[NREQ];
  logic [WIDTH-1:0] pbin[NREQ];

  initial begin
    // Fairness/backpressure table, starting from reset (pointer at 0).
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'h7, 2'd1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 4'hF, 2'd2};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'h1, 2'd0};
    vecs[6]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'hF, 2'd2};
    vecs[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 4'hF, 2'd2};
    vecs[8]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd3};
    vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'h8, 2'd3};
    exp_seq = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    rst       = 1'b1;
    req_valid = '0;
    req_bin   = '0;
    out_ready = 1'b0;
`ifdef GRAY_CONV_DECODE_EN
    req_dir   = '0;
`endif

    // Reset, then idle
    do_reset();

    // Table: round robin with bins 1,5,A,F plus backpressure rows
    req_bin = {4'hF, 4'hA, 4'h5, 4'h1};
    for (int v = 0; v < 11; v++) begin
      req_valid = vecs[v].valid;
      out_ready = vecs[v].ordy;
      #1;
      chk($sformatf("tbl%0d_ready", v), int'(req_ready), int'(vecs[v].exp_ready));
      tick();
      chk($sformatf("tbl%0d_valid", v), int'(out_valid), int'(vecs[v].exp_valid));
      chk($sformatf("tbl%0d_gray", v), int'(out_gray), int'(vecs[v].exp_gray));
      chk($sformatf("tbl%0d_id", v), int'(out_id), int'(vecs[v].exp_id));
    end

    // Exhaustive single requester streaming, no bubbles
    do_reset();
    req_valid = 4'b0001;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_bin = '0;
      req_bin[3:0] = 4'(i);
      #1;
      chk($sformatf("exh%0d_ready", i), int'(req_ready), 1);
      tick();
      chk($sformatf("exh%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("exh%0d_gray", i), int'(out_gray), int'(exp_seq[i]));
      chk($sformatf("exh%0d_id", i), int'(out_id), 0);
    end

    // Backpressure: hold gray C from requester 1 for 5 cycles
    do_reset();
    req_bin   = {4'h3, 4'h0, 4'h8, 4'h6};
    req_valid = 4'b0010;
    out_ready = 1'b0;
    tick();
    chk("bp_load_gray", int'(out_gray), 'hC);
    req_valid = 4'b1001;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d_ready", c), int'(req_ready), 0);
      tick();
      chk($sformatf("bp%0d_valid", c), int'(out_valid), 1);
      chk($sformatf("bp%0d_gray", c), int'(out_gray), 'hC);
      chk($sformatf("bp%0d_id", c), int'(out_id), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(req_ready), 'b1000);
    tick();
    chk("bp_release_gray", int'(out_gray), 'h2);
    chk("bp_release_id", int'(out_id), 3);

    // Reset mid-flight while full with pointer away from 0
    req_valid = 4'b0010;
    out_ready = 1'b1;
    tick();
    chk("mid_pre_id", int'(out_id), 1);
    req_valid = 4'b1001;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    chk("mid_rst_ready", int'(req_ready), 0);
    tick();
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_gray", int'(out_gray), 0);
    chk("mid_rst_id", int'(out_id), 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid_after_ready", int'(req_ready), 'b0001);
    tick();
    chk("mid_after_id", int'(out_id), 0);
    chk("mid_after_gray", int'(out_gray), 'h5);

`ifdef GRAY_CONV_DECODE_EN
    // Decode direction on requester 2
    do_reset();
    req_bin   = {4'h0, 4'hD, 4'h0, 4'h0};
    req_dir   = 4'b0100;
    req_valid = 4'b0100;
    out_ready = 1'b1;
    tick();
    chk("dec_gray", int'(out_gray), 'h9);
    chk("dec_dir", int'(out_dir), 1);
    chk("dec_id", int'(out_id), 2);
    req_dir = '0;
    tick();
    chk("enc_gray", int'(out_gray), 'hB);
    chk("enc_dir", int'(out_dir), 0);
    req_valid = '0;
`endif

    // Randomized run against the behavioural model
    do_reset();
    m_valid = 1'b0;
    m_gray  = '0;
    m_id    = 0;
    m_ptr   = 0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      pbin[i] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      int g;
      int exp_rdy;
      logic can;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pbin[i] = 4'($urandom_range(0, 15));
        end
        req_valid[i] = pend[i];
        req_bin[i*WIDTH +: WIDTH] = pbin[i];
      end
      out_ready = ($urandom_range(0, 3) != 0);
      can = !m_valid || out_ready;
      g = -1;
      if (can) begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && pend[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
      end
      exp_rdy = (g >= 0) ? (1 << g) : 0;
      #1;
      chk("rnd_ready", int'(req_ready), exp_rdy);
      tick();
      if (g >= 0) begin
        m_gray  = 4'((int'(pbin[g]) ^ (int'(pbin[g]) / 2)));
        m_id    = g;
        m_valid = 1'b1;
        m_ptr   = (g + 1) % NREQ;
        pend[g] = 1'b0;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      chk("rnd_valid", int'(out_valid), int'(m_valid));
      chk("rnd_gray", int'(out_gray), int'(m_gray));
      chk("rnd_id", int'(out_id), m_id);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
